// File: rtl/rect_flip_engine.sv
// In-place sub-rectangle mirror engine over a ROWS x COLS register matrix, one swap per cycle.
// Define RECT_FLIP_ERR_EN to reject reversed or out-of-range bounds with an err pulse.
module rect_flip_engine #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned RW        = (ROWS > 2) ? $clog2(ROWS) : 1,
  localparam int unsigned CW        = (COLS > 2) ? $clog2(COLS) : 1,
  localparam int unsigned AW        = $clog2(ROWS * COLS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [RW-1:0]         r1,
  input  logic [RW-1:0]         r2,
  input  logic [CW-1:0]         c1,
  input  logic [CW-1:0]         c2,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned NumElem = ROWS * COLS;
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StScan, StDone} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [NumElem];
  logic [1:0]            mode_q;
  logic [RW-1:0]         r1_q, r2_q, rlo_q, rhi_q, row_q;
  logic [CW-1:0]         c1_q, c2_q, clo_q, chi_q, col_q;

  logic [RW-1:0] rlo_n, rhi_n, pr;
  logic [CW-1:0] clo_n, chi_n, pc;
  logic [AW-1:0] addr_a, addr_b;
  logic          bad_req, do_swap, row_end, col_end;

  function automatic logic [RW-1:0] clamp_row(input logic [RW-1:0] x);
    return (32'(x) >= ROWS) ? RowLast : x;
  endfunction

  function automatic logic [CW-1:0] clamp_col(input logic [CW-1:0] x);
    return (32'(x) >= COLS) ? ColLast : x;
  endfunction

  always_comb begin
    rlo_n = clamp_row((r1_q < r2_q) ? r1_q : r2_q);
    rhi_n = clamp_row((r1_q < r2_q) ? r2_q : r1_q);
    clo_n = clamp_col((c1_q < c2_q) ? c1_q : c2_q);
    chi_n = clamp_col((c1_q < c2_q) ? c2_q : c1_q);
  end

`ifdef RECT_FLIP_ERR_EN
  assign bad_req = (r1_q > r2_q) || (c1_q > c2_q) || (32'(r1_q) >= ROWS) || (32'(r2_q) >= ROWS)
                || (32'(c1_q) >= COLS) || (32'(c2_q) >= COLS);
  assign err     = (state_q == StSetup) && bad_req;
`else
  assign bad_req = 1'b0;
  assign err     = 1'b0;
`endif

  // Mirror sums carry one extra bit; the result always lands back inside the rectangle.
  always_comb begin
    pr      = mode_q[1] ? RW'({1'b0, rlo_q} + {1'b0, rhi_q} - {1'b0, row_q}) : row_q;
    pc      = mode_q[0] ? CW'({1'b0, clo_q} + {1'b0, chi_q} - {1'b0, col_q}) : col_q;
    addr_a  = AW'(row_q) * AW'(COLS) + AW'(col_q);
    addr_b  = AW'(pr) * AW'(COLS) + AW'(pc);
    // Only the lower address of each pair swaps, so every pair moves exactly once.
    do_swap = (state_q == StScan) && (addr_a < addr_b);
    row_end = (row_q == rhi_q);
    col_end = (col_q == chi_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSetup;
      StSetup: state_d = bad_req ? StIdle : StScan;
      StScan:  if (row_end && col_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      rlo_q   <= '0;
      rhi_q   <= '0;
      clo_q   <= '0;
      chi_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        mode_q <= mode;
        r1_q   <= r1;
        r2_q   <= r2;
        c1_q   <= c1;
        c2_q   <= c2;
      end
      if (state_q == StSetup) begin
        rlo_q <= rlo_n;
        rhi_q <= rhi_n;
        clo_q <= clo_n;
        chi_q <= chi_n;
        row_q <= rlo_n;
        col_q <= clo_n;
      end
      if (state_q == StScan) begin
        if (col_end) begin
          col_q <= clo_q;
          if (!row_end) row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumElem; i++) mem_q[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && !busy && (32'(wr_addr) < NumElem)) mem_q[wr_addr] <= wr_data;
      if (do_swap) begin
        mem_q[addr_a] <= mem_q[addr_b];
        mem_q[addr_b] <= mem_q[addr_a];
      end
      rd_data <= (32'(rd_addr) < NumElem) ? mem_q[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_rect_flip_engine.sv
// Self-checking bench for rect_flip_engine: vector table, hand sequences and randomized runs
// compared against a mirror-based matrix model.
module tb_rect_flip_engine;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int N    = ROWS * COLS;
  localparam int RW   = 2;
  localparam int CW   = 2;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          start;
  logic [1:0]    mode;
  logic [RW-1:0] r1, r2;
  logic [CW-1:0] c1, c2;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;
  int model[N];

  always #5 clk = ~clk;

  rect_flip_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .mode(mode), .r1(r1), .r2(r2),
    .c1(c1), .c2(c2), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    bit         reload;
    logic [1:0] mode;
    int         r1, r2, c1, c2;
    int         lat;
    bit         bad;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: every element in the rectangle takes the value of its mirror image.
  task automatic model_flip(input logic [1:0] m, input int a1, input int a2, input int b1,
                            input int b2);
    int old[N];
    int rlo, rhi, clo, chi, pr, pc;
    rlo = (a1 < a2) ? a1 : a2;
    rhi = (a1 < a2) ? a2 : a1;
    clo = (b1 < b2) ? b1 : b2;
    chi = (b1 < b2) ? b2 : b1;
    if (rhi > ROWS - 1) rhi = ROWS - 1;
    if (rlo > ROWS - 1) rlo = ROWS - 1;
    if (chi > COLS - 1) chi = COLS - 1;
    if (clo > COLS - 1) clo = COLS - 1;
    old = model;
    for (int r = rlo; r <= rhi; r++) begin
      for (int c = clo; c <= chi; c++) begin
        pr = m[1] ? (rlo + rhi - r) : r;
        pc = m[0] ? (clo + chi - c) : c;
        model[r * COLS + c] = old[pr * COLS + pc];
      end
    end
  endtask

  task automatic write_elem(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic read_elem(input int a, output int d);
    rd_addr = AW'(a);
    @(posedge clk);
    #1;
    d = int'(rd_data);
  endtask

  task automatic check_matrix(input string name);
    int d;
    for (int i = 0; i < N; i++) begin
      read_elem(i, d);
      check($sformatf("%s elem[%0d]", name, i), d, model[i]);
    end
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++) begin
      write_elem(i, i);
      model[i] = i;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input int a1, input int a2,
                        input int b1, input int b2, input bit cw, input int caddr,
                        input int cdata, input int exp_lat, input bit exp_err);
    int k;
    bit busy_ok;
    bit got_done, got_err;
    mode    = m;
    r1      = RW'(a1);
    r2      = RW'(a2);
    c1      = CW'(b1);
    c2      = CW'(b2);
    start   = 1'b1;
    wr_en   = cw;
    wr_addr = AW'(caddr);
    wr_data = DW'(cdata);
    @(posedge clk);
    #1;
    start   = 1'b0;
    wr_en   = 1'b0;
    if (cw) model[caddr] = cdata;
    busy_ok = 1'b1;
    for (k = 1; k < 100; k++) begin
      if (done || err) break;
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    got_done = done;
    got_err  = err;
    check({name, " latency"}, k, exp_lat);
    check({name, " busy"}, int'(busy_ok), 1);
    check({name, " done"}, int'(got_done), int'(!exp_err));
    check({name, " err"}, int'(got_err), int'(exp_err));
    if (!exp_err) model_flip(m, a1, a2, b1, b2);
    @(posedge clk);
    #1;
    check({name, " idle after"}, int'(busy || done || err), 0);
  endtask

  initial begin
    int exp_lat, ndone, done_at, a1, a2, b1, b2, lo, hi, clo, chi;
    bit exp_err, busy_ok, bad, cw;
    logic [1:0] m;

    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    start   = 1'b0;
    mode    = '0;
    r1      = '0;
    r2      = '0;
    c1      = '0;
    c2      = '0;
    for (int i = 0; i < N; i++) model[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    check("reset rd_data", int'(rd_data), 0);
    reset_n = 1'b1;
    check_matrix("after reset");

    vecs[0] = '{1'b1, 2'b01, 1, 3, 1, 2, 8, 1'b0};
    vecs[1] = '{1'b1, 2'b10, 1, 3, 1, 2, 8, 1'b0};
    vecs[2] = '{1'b1, 2'b11, 1, 3, 1, 2, 8, 1'b0};
    vecs[3] = '{1'b0, 2'b11, 1, 3, 1, 2, 8, 1'b0};
    vecs[4] = '{1'b1, 2'b01, 3, 1, 1, 2, 8, 1'b1};
    vecs[5] = '{1'b0, 2'b00, 0, 3, 0, 3, 18, 1'b0};
    vecs[6] = '{1'b0, 2'b11, 2, 2, 1, 1, 3, 1'b0};
    vecs[7] = '{1'b0, 2'b01, 0, 0, 3, 0, 6, 1'b1};
    vecs[8] = '{1'b0, 2'b10, 0, 3, 2, 2, 6, 1'b0};

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].reload) load_identity();
      exp_lat = vecs[i].lat;
      exp_err = 1'b0;
`ifdef RECT_FLIP_ERR_EN
      if (vecs[i].bad) begin
        exp_lat = 1;
        exp_err = 1'b1;
      end
`endif
      run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].r1, vecs[i].r2, vecs[i].c1,
             vecs[i].c2, 1'b0, 0, 0, exp_lat, exp_err);
      check_matrix($sformatf("vec%0d", i));
    end

    // Write in the start cycle lands before the flip sees the matrix.
    load_identity();
    run_op("start+write", 2'b01, 1, 3, 1, 2, 1'b1, 5, 99, 8, 1'b0);
    check_matrix("start+write");

    // Start and write during a run are dropped; start on the done cycle is ignored.
    load_identity();
    mode  = 2'b11;
    r1    = 2'd0;
    r2    = 2'd3;
    c1    = 2'd0;
    c2    = 2'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    ndone   = 0;
    done_at = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        ndone++;
        done_at = k;
      end
      if (k == 19) check("done-cycle start ignored", int'(busy), 0);
      if (k <= 18 && !busy) busy_ok = 1'b0;
      if (k == 3) begin
        start   = 1'b1;
        mode    = 2'b01;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'hAA;
      end else if (done) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wr_en = 1'b0;
    model_flip(2'b11, 0, 3, 0, 3);
    check("busy run done count", ndone, 1);
    check("busy run done cycle", done_at, 18);
    check("busy run busy held", int'(busy_ok), 1);
    check_matrix("busy run");

    // Asynchronous reset in the third scan cycle.
    load_identity();
    mode  = 2'b11;
    r1    = 2'd0;
    r2    = 2'd3;
    c1    = 2'd0;
    c2    = 2'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid reset busy", int'(busy), 0);
    check("mid reset done", int'(done), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ndone   = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) ndone++;
      @(posedge clk);
      #1;
    end
    check("no activity after reset", ndone, 0);
    for (int i = 0; i < N; i++) model[i] = 0;
    check_matrix("mid reset");
    for (int i = 0; i < N; i++) begin
      write_elem(i, i + 20);
      model[i] = i + 20;
    end
    run_op("post reset", 2'b01, 0, 3, 0, 3, 1'b0, 0, 0, 18, 1'b0);
    check_matrix("post reset");

    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        a1 = int'($urandom_range(0, N - 1));
        b1 = int'($urandom_range(0, 255));
        write_elem(a1, b1);
        model[a1] = b1;
      end
      m   = 2'($urandom_range(0, 3));
      a1  = int'($urandom_range(0, ROWS - 1));
      a2  = int'($urandom_range(0, ROWS - 1));
      b1  = int'($urandom_range(0, COLS - 1));
      b2  = int'($urandom_range(0, COLS - 1));
      lo  = (a1 < a2) ? a1 : a2;
      hi  = (a1 < a2) ? a2 : a1;
      clo = (b1 < b2) ? b1 : b2;
      chi = (b1 < b2) ? b2 : b1;
      bad = (a1 > a2) || (b1 > b2);
      cw  = ($urandom_range(0, 3) == 0);
      exp_lat = 2 + (hi - lo + 1) * (chi - clo + 1);
      exp_err = 1'b0;
`ifdef RECT_FLIP_ERR_EN
      if (bad) begin
        exp_lat = 1;
        exp_err = 1'b1;
      end
`endif
      run_op($sformatf("rand%0d", it), m, a1, a2, b1, b2, cw,
             int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)), exp_lat, exp_err);
      check_matrix($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
